// File: rtl/entrada_multifase.sv
// Multi-phase switch input reader: assembles an N_FASES-chunk word from debounced
// confirm-key presses and hands it to the processor through a valid/ack handshake.
module entrada_multifase #(
  parameter int CHAVES_W = 16,
  parameter int N_FASES  = 2,
  parameter int DADO_W   = CHAVES_W * N_FASES,
  parameter int DEBOUNCE = 50000,
  parameter int FASE_W   = (N_FASES > 1) ? $clog2(N_FASES) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHAVES_W-1:0] chaves,
  input  logic                confirma,
  input  logic                controle,
  input  logic                ack,
  output logic [DADO_W-1:0]   dado,
  output logic                dado_valido,
  output logic [FASE_W-1:0]   fase,
  output logic                aguardando
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    COLETA,
    PRONTO
  } estado_t;

  // Chunk idx lands in the word with chunk 0 in the most significant position.
  function automatic logic [DADO_W-1:0] insere_fatia(
    input logic [DADO_W-1:0]   base,
    input logic [CHAVES_W-1:0] fatia,
    input logic [FASE_W-1:0]   idx
  );
    logic [DADO_W-1:0] r;
    r = base;
    for (int i = 0; i < N_FASES; i++) begin
      if (idx == FASE_W'(i)) r[(N_FASES-1-i)*CHAVES_W +: CHAVES_W] = fatia;
    end
    return r;
  endfunction

  logic                conf_p0, conf_p1;
  logic [CHAVES_W-1:0] chaves_p0, chaves_p1;
  logic [CNT_W-1:0]    cnt_p2;
  logic                conf_est, conf_est_q;
  logic                captura;

  // Stage p0/p1: two-flop synchronizers; stage p2: debounce of the confirm key
  always_ff @(posedge clock) begin
    if (reset) begin
      conf_p0    <= 1'b0;
      conf_p1    <= 1'b0;
      chaves_p0  <= '0;
      chaves_p1  <= '0;
      cnt_p2     <= '0;
      conf_est   <= 1'b0;
      conf_est_q <= 1'b0;
    end else begin
      conf_p0    <= confirma;
      conf_p1    <= conf_p0;
      chaves_p0  <= chaves;
      chaves_p1  <= chaves_p0;
      conf_est_q <= conf_est;
      if (conf_p1 == conf_est) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_W'(DEBOUNCE - 1)) begin
        conf_est <= conf_p1;
        cnt_p2   <= '0;
      end else begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end
    end
  end

  // Only the press edge commits a chunk; releases are ignored.
  assign captura = conf_est & ~conf_est_q;

  estado_t             estado, estado_nxt;
  logic [DADO_W-1:0]   shadow, shadow_nxt;
  logic [DADO_W-1:0]   dado_nxt;
  logic                valido_nxt;
  logic [FASE_W-1:0]   fase_nxt;
  logic [DADO_W-1:0]   merged;

  always_comb begin
    estado_nxt = estado;
    shadow_nxt = shadow;
    dado_nxt   = dado;
    valido_nxt = dado_valido;
    fase_nxt   = fase;
    merged     = insere_fatia(shadow, chaves_p1, fase);
    case (estado)
      OCIOSO: begin
        if (controle && !dado_valido) begin
          estado_nxt = COLETA;
          fase_nxt   = '0;
          shadow_nxt = '0;
        end
      end
      COLETA: begin
        // Dropping controle aborts even when a capture arrives in the same cycle.
        if (!controle) begin
          estado_nxt = OCIOSO;
          fase_nxt   = '0;
          shadow_nxt = '0;
        end else if (captura) begin
          shadow_nxt = merged;
          if (fase == FASE_W'(N_FASES - 1)) begin
            dado_nxt   = merged;
            valido_nxt = 1'b1;
            fase_nxt   = '0;
            estado_nxt = PRONTO;
          end else begin
            fase_nxt = fase + FASE_W'(1);
          end
        end
      end
      PRONTO: begin
        if (ack) begin
          valido_nxt = 1'b0;
          estado_nxt = OCIOSO;
        end
      end
      default: begin
        estado_nxt = OCIOSO;
        fase_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      shadow      <= '0;
      dado        <= '0;
      dado_valido <= 1'b0;
      fase        <= '0;
    end else begin
      estado      <= estado_nxt;
      shadow      <= shadow_nxt;
      dado        <= dado_nxt;
      dado_valido <= valido_nxt;
      fase        <= fase_nxt;
    end
  end

  assign aguardando = (estado == COLETA);

endmodule

// File: tb/tb_entrada_multifase.sv
// Directed bench for entrada_multifase: a 16x2 instance driven from a vector table,
// plus 8x4 and 8x1 instances for the generalised widths.
module tb_entrada_multifase;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ch_a;
  logic        cf_a, ctl_a, ack_a;
  logic [31:0] dado_a;
  logic        vld_a, ag_a;
  logic [0:0]  fase_a;
  logic [7:0]  ch_b;
  logic        cf_b, ctl_b, ack_b;
  logic [31:0] dado_b;
  logic        vld_b, ag_b;
  logic [1:0]  fase_b;
  logic [7:0]  ch_c;
  logic        cf_c, ctl_c, ack_c;
  logic [7:0]  dado_c;
  logic        vld_c, ag_c;
  logic [0:0]  fase_c;

  always #5 clk = ~clk;

  entrada_multifase #(.CHAVES_W(16), .N_FASES(2), .DEBOUNCE(DEB)) dut_a (
    .clock(clk), .reset(rst), .chaves(ch_a), .confirma(cf_a), .controle(ctl_a),
    .ack(ack_a), .dado(dado_a), .dado_valido(vld_a), .fase(fase_a), .aguardando(ag_a));

  entrada_multifase #(.CHAVES_W(8), .N_FASES(4), .DEBOUNCE(DEB)) dut_b (
    .clock(clk), .reset(rst), .chaves(ch_b), .confirma(cf_b), .controle(ctl_b),
    .ack(ack_b), .dado(dado_b), .dado_valido(vld_b), .fase(fase_b), .aguardando(ag_b));

  entrada_multifase #(.CHAVES_W(8), .N_FASES(1), .DEBOUNCE(DEB)) dut_c (
    .clock(clk), .reset(rst), .chaves(ch_c), .confirma(cf_c), .controle(ctl_c),
    .ack(ack_c), .dado(dado_c), .dado_valido(vld_c), .fase(fase_c), .aguardando(ag_c));

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {OP_CTL, OP_PRESS, OP_ACK} op_t;
  typedef struct {
    op_t         op;
    logic [15:0] val;
    logic [31:0] dado;
    logic        vld;
    logic [1:0]  fase;
    logic        ag;
  } vec_t;

  vec_t tab[18];

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nome, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] d, input logic v,
                       input logic [1:0] f, input logic g);
    chk({tag, ".dado"}, dado_a, d);
    chk({tag, ".valido"}, 32'(vld_a), 32'(v));
    chk({tag, ".fase"}, 32'(fase_a), 32'(f));
    chk({tag, ".aguardando"}, 32'(ag_a), 32'(g));
  endtask

  // Raises the key one edge after the chunk is set; returns just after the capture edge.
  task automatic press_rise(input int which, input logic [15:0] val);
    case (which)
      0:       ch_a = val;
      1:       ch_b = val[7:0];
      default: ch_c = val[7:0];
    endcase
    @(posedge clk); #1;
    case (which)
      0:       cf_a = 1'b1;
      1:       cf_b = 1'b1;
      default: cf_c = 1'b1;
    endcase
    repeat (DEB + 3) @(posedge clk);
    #1;
  endtask

  task automatic release_key(input int which);
    case (which)
      0:       cf_a = 1'b0;
      1:       cf_b = 1'b0;
      default: cf_c = 1'b0;
    endcase
    repeat (DEB + 4) @(posedge clk);
    #1;
  endtask

  task automatic bounce_test();
    int lat;
    ch_a = 16'h00FF;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      cf_a = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cf_a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    chk("bounce.no_capture", 32'(fase_a), 32'd0);
    cf_a = 1'b1;
    @(posedge clk); #1;
    // Edges counted after the first edge that samples the held key.
    lat = 0;
    while (fase_a == 1'b0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bounce.latency", 32'(lat), 32'(2 + DEB));
    chk("bounce.fase", 32'(fase_a), 32'd1);
    release_key(0);
    chk("bounce.single", 32'(fase_a), 32'd1);
    chk("bounce.aguardando", 32'(ag_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = '{OP_CTL,   16'h0001, 32'h0000_0000, 1'b0, 2'd0, 1'b1};
    tab[1]  = '{OP_PRESS, 16'hABCD, 32'h0000_0000, 1'b0, 2'd1, 1'b1};
    tab[2]  = '{OP_PRESS, 16'h1234, 32'hABCD_1234, 1'b1, 2'd0, 1'b0};
    tab[3]  = '{OP_ACK,   16'h0000, 32'hABCD_1234, 1'b0, 2'd0, 1'b0};
    tab[4]  = '{OP_CTL,   16'h0000, 32'hABCD_1234, 1'b0, 2'd0, 1'b0};
    tab[5]  = '{OP_CTL,   16'h0001, 32'hABCD_1234, 1'b0, 2'd0, 1'b1};
    tab[6]  = '{OP_PRESS, 16'h0001, 32'hABCD_1234, 1'b0, 2'd1, 1'b1};
    tab[7]  = '{OP_PRESS, 16'h0002, 32'h0001_0002, 1'b1, 2'd0, 1'b0};
    tab[8]  = '{OP_PRESS, 16'hFFFF, 32'h0001_0002, 1'b1, 2'd0, 1'b0};
    tab[9]  = '{OP_CTL,   16'h0000, 32'h0001_0002, 1'b1, 2'd0, 1'b0};
    tab[10] = '{OP_ACK,   16'h0000, 32'h0001_0002, 1'b0, 2'd0, 1'b0};
    tab[11] = '{OP_ACK,   16'h0000, 32'h0001_0002, 1'b0, 2'd0, 1'b0};
    tab[12] = '{OP_PRESS, 16'h7777, 32'h0001_0002, 1'b0, 2'd0, 1'b0};
    tab[13] = '{OP_CTL,   16'h0001, 32'h0001_0002, 1'b0, 2'd0, 1'b1};
    tab[14] = '{OP_PRESS, 16'hCAFE, 32'h0001_0002, 1'b0, 2'd1, 1'b1};
    tab[15] = '{OP_PRESS, 16'hBEEF, 32'hCAFE_BEEF, 1'b1, 2'd0, 1'b0};
    tab[16] = '{OP_ACK,   16'h0000, 32'hCAFE_BEEF, 1'b0, 2'd0, 1'b0};
    tab[17] = '{OP_CTL,   16'h0001, 32'hCAFE_BEEF, 1'b0, 2'd0, 1'b1};

    ch_a = '0; cf_a = 0; ctl_a = 0; ack_a = 0;
    ch_b = '0; cf_b = 0; ctl_b = 0; ack_b = 0;
    ch_c = '0; cf_c = 0; ctl_c = 0; ack_c = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_a("reset", 32'h0, 1'b0, 2'd0, 1'b0);
    chk("reset.b.dado", dado_b, 32'h0);
    chk("reset.c.dado", 32'(dado_c), 32'h0);

    for (int i = 0; i < 18; i++) begin
      // Bounce and abort exercise the word in progress after the first ack.
      if (i == 4) bounce_test();
      case (tab[i].op)
        OP_CTL: begin
          ctl_a = tab[i].val[0];
          repeat (2) @(posedge clk);
          #1;
          chk_a($sformatf("v%0d", i), tab[i].dado, tab[i].vld, tab[i].fase, tab[i].ag);
        end
        OP_ACK: begin
          ack_a = 1'b1;
          @(posedge clk); #1;
          ack_a = 1'b0;
          chk_a($sformatf("v%0d", i), tab[i].dado, tab[i].vld, tab[i].fase, tab[i].ag);
        end
        default: begin
          press_rise(0, tab[i].val);
          chk_a($sformatf("v%0d", i), tab[i].dado, tab[i].vld, tab[i].fase, tab[i].ag);
          release_key(0);
        end
      endcase
    end

    // Capture and controle fall on the same edge: the abort wins.
    ch_a = 16'h1111;
    @(posedge clk); #1;
    cf_a = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    #1;
    ctl_a = 1'b0;
    @(posedge clk); #1;
    chk_a("race", 32'hCAFE_BEEF, 1'b0, 2'd0, 1'b0);
    release_key(0);

    // Reset in the middle of a word.
    ctl_a = 1'b1;
    press_rise(0, 16'hDEAD);
    chk("midreset.fase_before", 32'(fase_a), 32'd1);
    release_key(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_a("midreset", 32'h0, 1'b0, 2'd0, 1'b0);
    press_rise(0, 16'h5555);
    chk("after_reset.fase", 32'(fase_a), 32'd1);
    release_key(0);
    press_rise(0, 16'h1234);
    chk_a("after_reset", 32'h5555_1234, 1'b1, 2'd0, 1'b0);
    release_key(0);

    // Four 8-bit chunks.
    ctl_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press_rise(1, 16'(8'h11 * (i + 1)));
      chk($sformatf("b.fase%0d", i), 32'(fase_b), 32'((i + 1) % 4));
      release_key(1);
    end
    chk("b.dado", dado_b, 32'h1122_3344);
    chk("b.valido", 32'(vld_b), 32'd1);
    chk("b.aguardando", 32'(ag_b), 32'd0);

    // Single-chunk word.
    ctl_c = 1'b1;
    press_rise(2, 16'h005A);
    chk("c.dado", 32'(dado_c), 32'h5A);
    chk("c.valido", 32'(vld_c), 32'd1);
    chk("c.fase", 32'(fase_c), 32'd0);
    release_key(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
